bcd_updown_seq: RTL and testbench
=================================

# bcd_updown_seq

Sequencer for a multi-digit up/down BCD counter. It accepts a start command with a BCD target and a direction, then steps the counter one count at a time at a programmable rate until the count equals the target. It reports completion with a single-cycle done pulse. It sits between the control logic and the BCD counter datapath, and owns the counter's enable and direction so that no other logic drives them.

## Interface
- DIGITS, default 2: number of cascaded BCD digits (1–4).
- STEP_DIV, default 1: clock cycles between successive count steps while running (1–255).
- clk  in  1  single system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request to begin a run; sampled only in IDLE.
- x  in  1  direction: 0 = count up, 1 = count down; latched on start.
- target  in  4*DIGITS  BCD target value, digit 0 in [3:0]; latched on start.
- abort  in  1  ends a run immediately and holds the current count.
- count  out  4*DIGITS  current BCD count.
- busy  out  1  high while a run is in progress.
- done  out  1  one-cycle pulse when the count reaches the target.
- err  out  1  one-cycle pulse when start is rejected because a target digit is greater than 9.

## Operation
- FSM states: IDLE, RUN.
- Reset: state IDLE; count all zeros; busy, done, err = 0; step divider = 0; latched dir and target = 0.
- IDLE, start=1, target valid, count≠target: latch x and target, reset the divider, go to RUN.
- IDLE, start=1, target valid, count=target: pulse done; stay in IDLE; busy stays 0.
- IDLE, start=1, any target digit >9: pulse err; no latch; count unchanged.
- RUN: the divider counts 0..STEP_DIV-1. On wrap, count steps by ±1 in BCD.
  - Digit carry on 9→0 (up); digit borrow on 0→9 (down).
  - Full wrap: all-9s → all-0s going up; all-0s → all-9s going down.
- RUN, step result = latched target: pulse done in the same cycle busy drops; go to IDLE.
- start in RUN is ignored. x and target changes in RUN are ignored.
- abort in RUN: go to IDLE next edge; count keeps its pre-edge value (no step on that edge, even if the divider wraps); no done pulse.
- abort in IDLE: no effect.
- abort and start in the same IDLE cycle: start wins.
- rst in any state, including mid-run: full reset values on the next edge; a pending done is discarded.

## Timing
- Let E0 be the edge on which start is accepted.
- busy is registered high after E0.
- The count changes after edges E0+k·STEP_DIV, for k = 1..N, where N is the step distance.
  - Up: N = (target − count) mod 10^DIGITS. Down: N = (count − target) mod 10^DIGITS.
- done is high, and busy low, in the cycle following edge E0+N·STEP_DIV.
- Same-value start (N = 0): done is high in the cycle after E0.
- Invalid target: err is high in the cycle after E0.
- done and err are never high together. Neither is high for more than one cycle.
- A new start is accepted no earlier than the cycle done is high; back-to-back runs are allowed.

## Configuration
- Macro: BCD_SEQ_LOAD_EN.
- Defined: adds ports load (in, 1) and load_value (in, 4*DIGITS).
  - In IDLE, load=1 with a valid BCD value sets count = load_value on the next edge.
  - load takes priority over start in the same cycle.
  - An invalid load_value pulses err and leaves count unchanged.
  - load is ignored in RUN.
- Undefined: the ports are absent. count changes only by stepping or by reset.

## Structure
- Shared package bcd_seq_pkg holds:
  - state enum (IDLE, RUN);
  - BCD_MAX = 4'd9;
  - DIR_UP = 1'b0, DIR_DN = 1'b1;
  - a function that checks a vector for valid BCD digits.
- Sub-module bcd_digit: one 4-bit up/down BCD digit with enable, direction, carry/borrow in and carry/borrow out. It is instantiated DIGITS times as a ripple chain; the sequencer drives the enable of digit 0.

## Test plan
- Reset, then start with x=0, target=8'h05, count=00 (DIGITS=2, STEP_DIV=1): count steps 01..05 on consecutive cycles; done pulses once, 5 cycles after E0; busy low from that same cycle.
- Count=98, start with x=0, target=8'h01: sequence 99, 00, 01 (up wrap); done pulses after 3 steps.
- Count=01, start with x=1, target=8'h97: sequence 00, 99, 98, 97 (down wrap); done pulses after 4 steps.
- Start with target=8'h1A: err pulses one cycle; count unchanged; busy stays 0. Start with target equal to count: done the next cycle; busy stays 0.
- STEP_DIV=3, run 00→04, abort asserted at count=02: busy drops next cycle; count holds 02; no done. rst asserted mid-run: count=00, all flags 0 on the next edge.
- With BCD_SEQ_LOAD_EN defined, load=1 with load_value=8'h42 in IDLE: count=42. Then start with x=1, target=8'h40: sequence 41, 40; done pulses.

Source files
------------

// File: rtl/bcd_seq_pkg.sv
// Shared types and helpers for the BCD up/down sequencer and its digit cells.
package bcd_seq_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  localparam logic [3:0] BCD_MAX = 4'd9;

  localparam logic DIR_UP = 1'b0;
  localparam logic DIR_DN = 1'b1;

  // True when every nibble of v holds 0..9. Narrower vectors are
  // zero-extended by the caller; zero nibbles are always valid.
  function automatic logic is_bcd(input logic [15:0] v);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (v[4*i +: 4] > BCD_MAX) ok = 1'b0;
    end
    return ok;
  endfunction

endpackage

// File: rtl/bcd_digit.sv
// One BCD digit of the ripple counter: steps up or down when enabled,
// raises cout_o when it rolls over (9->0 up, 0->9 down) so the next
// digit steps on the same edge. nxt_o exposes the value after this edge.
module bcd_digit
  import bcd_seq_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       en_i,
  input  logic       dir_i,
  input  logic       load_i,
  input  logic [3:0] load_val_i,
  output logic [3:0] q_o,
  output logic [3:0] nxt_o,
  output logic       cout_o
);

  logic [3:0] q_q;
  logic [3:0] q_d;

  // Next digit value for a step in the latched direction.
  always_comb begin
    // NOTE: default first so every path assigns q_d and no latch is inferred.
    q_d = q_q;
    if (en_i) begin
      if (dir_i == DIR_UP) q_d = (q_q == BCD_MAX) ? 4'd0 : q_q + 4'd1;
      else                 q_d = (q_q == 4'd0) ? BCD_MAX : q_q - 4'd1;
    end
  end

  assign cout_o = en_i && ((dir_i == DIR_UP) ? (q_q == BCD_MAX) : (q_q == 4'd0));
  assign nxt_o  = q_d;
  assign q_o    = q_q;

  // Digit register: reset, load, or step.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments for all clocked state, avoiding ordering races.
    if (rst)         q_q <= 4'd0;
    else if (load_i) q_q <= load_val_i;
    else             q_q <= q_d;
  end

endmodule

// File: rtl/bcd_updown_seq.sv
// Sequencer for a DIGITS-wide up/down BCD counter. A start latches a
// target and direction, then the counter steps once every STEP_DIV
// cycles until it equals the target, ending with a one-cycle done pulse.
// Optional macro BCD_SEQ_LOAD_EN adds a direct load of the count in IDLE.
module bcd_updown_seq
  import bcd_seq_pkg::*;
#(
  parameter int DIGITS   = 2,
  parameter int STEP_DIV = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                x,
  input  logic [4*DIGITS-1:0] target,
  input  logic                abort,
`ifdef BCD_SEQ_LOAD_EN
  input  logic                load,
  input  logic [4*DIGITS-1:0] load_value,
`endif
  output logic [4*DIGITS-1:0] count,
  output logic                busy,
  output logic                done,
  output logic                err
);

  localparam int         W        = 4 * DIGITS;
  localparam logic [7:0] DIV_LAST = 8'(STEP_DIV - 1);

  state_e         state_q, state_d;
  logic [7:0]     div_q, div_d;
  logic           dir_q, dir_d;
  logic [W-1:0]   tgt_q, tgt_d;
  logic           done_q, done_d;
  logic           err_q, err_d;

  logic [W-1:0]   cnt;
  logic [W-1:0]   nxt;
  logic           step_en;
  logic           load_req;
  logic           load_en;
  logic [W-1:0]   load_val;
  logic           carry_unused;

`ifdef BCD_SEQ_LOAD_EN
  assign load_req = load;
  assign load_val = load_value;
`else
  assign load_req = 1'b0;
  assign load_val = '0;
`endif

  // A step happens on a divider wrap while running, unless aborted.
  assign step_en = (state_q == RUN) && !abort && (div_q == DIV_LAST);

  for (genvar i = 0; i < DIGITS; i++) begin : g_dig
    logic en;
    logic cout;
    if (i == 0) begin : g_first
      assign en = step_en;
    end else begin : g_rest
      assign en = g_dig[i-1].cout;
    end
    bcd_digit u_digit (
      .clk        (clk),
      .rst        (rst),
      .en_i       (en),
      .dir_i      (dir_q),
      .load_i     (load_en),
      .load_val_i (load_val[4*i +: 4]),
      .q_o        (cnt[4*i +: 4]),
      .nxt_o      (nxt[4*i +: 4]),
      .cout_o     (cout)
    );
  end

  // The top digit's rollover is the full wrap; nothing beyond it consumes it.
  assign carry_unused = g_dig[DIGITS-1].cout;

  // Next-state, divider, latches and pulse generation.
  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    dir_d   = dir_q;
    tgt_d   = tgt_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    load_en = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (load_req) begin
          if (is_bcd(16'(load_val))) load_en = 1'b1;
          else                       err_d   = 1'b1;
        end else if (start) begin
          if (!is_bcd(16'(target))) begin
            err_d = 1'b1;
          end else if (target == cnt) begin
            done_d = 1'b1;
          end else begin
            state_d = RUN;
            dir_d   = x;
            tgt_d   = target;
            div_d   = '0;
          end
        end
      end
      RUN: begin
        if (abort) begin
          state_d = IDLE;
        end else if (step_en) begin
          div_d = '0;
          if (nxt == tgt_q) begin
            done_d  = 1'b1;
            state_d = IDLE;
          end
        end else begin
          div_d = div_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Control registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      div_q   <= '0;
      dir_q   <= DIR_UP;
      tgt_q   <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      dir_q   <= dir_d;
      tgt_q   <= tgt_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign count = cnt;
  assign busy  = (state_q == RUN);
  assign done  = done_q;
  assign err   = err_q;

endmodule

// File: tb/tb_bcd_updown_seq.sv
// Directed bench for bcd_updown_seq: one instance at STEP_DIV=1, one at
// STEP_DIV=3. Load-port steps are included when BCD_SEQ_LOAD_EN is defined.
module tb_bcd_updown_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst1, start1, x1, abort1;
  logic [7:0] tgt1;
  logic [7:0] cnt1;
  logic       busy1, done1, err1;

  logic       rst3, start3, x3, abort3;
  logic [7:0] tgt3;
  logic [7:0] cnt3;
  logic       busy3, done3, err3;

`ifdef BCD_SEQ_LOAD_EN
  logic       load1, load3;
  logic [7:0] lval1, lval3;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  bcd_updown_seq #(.DIGITS(2), .STEP_DIV(1)) u_dut1 (
    .clk        (clk),
    .rst        (rst1),
    .start      (start1),
    .x          (x1),
    .target     (tgt1),
    .abort      (abort1),
`ifdef BCD_SEQ_LOAD_EN
    .load       (load1),
    .load_value (lval1),
`endif
    .count      (cnt1),
    .busy       (busy1),
    .done       (done1),
    .err        (err1)
  );

  bcd_updown_seq #(.DIGITS(2), .STEP_DIV(3)) u_dut3 (
    .clk        (clk),
    .rst        (rst3),
    .start      (start3),
    .x          (x3),
    .target     (tgt3),
    .abort      (abort3),
`ifdef BCD_SEQ_LOAD_EN
    .load       (load3),
    .load_value (lval3),
`endif
    .count      (cnt3),
    .busy       (busy3),
    .done       (done3),
    .err        (err3)
  );

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic flags1(input string tag, input logic [7:0] c, input logic b,
                        input logic d, input logic e);
    check({tag, ".count"}, 16'(cnt1), 16'(c));
    check({tag, ".busy"},  16'(busy1), 16'(b));
    check({tag, ".done"},  16'(done1), 16'(d));
    check({tag, ".err"},   16'(err1),  16'(e));
  endtask

  task automatic flags3(input string tag, input logic [7:0] c, input logic b,
                        input logic d, input logic e);
    check({tag, ".count"}, 16'(cnt3), 16'(c));
    check({tag, ".busy"},  16'(busy3), 16'(b));
    check({tag, ".done"},  16'(done3), 16'(d));
    check({tag, ".err"},   16'(err3),  16'(e));
  endtask

  logic [7:0] seq_b [3] = '{8'h99, 8'h00, 8'h01};
  logic [7:0] seq_c [4] = '{8'h00, 8'h99, 8'h98, 8'h97};

  initial begin
    bit ok;
    rst1 = 1'b1; start1 = 1'b0; x1 = 1'b0; abort1 = 1'b0; tgt1 = 8'h00;
    rst3 = 1'b1; start3 = 1'b0; x3 = 1'b0; abort3 = 1'b0; tgt3 = 8'h00;
`ifdef BCD_SEQ_LOAD_EN
    load1 = 1'b0; lval1 = 8'h00; load3 = 1'b0; lval3 = 8'h00;
`endif
    tick();
    tick();
    rst1 = 1'b0;
    rst3 = 1'b0;
    flags1("reset1", 8'h00, 1'b0, 1'b0, 1'b0);
    flags3("reset3", 8'h00, 1'b0, 1'b0, 1'b0);

    // 00 -> 05 up, one step per cycle.
    start1 = 1'b1; x1 = 1'b0; tgt1 = 8'h05;
    tick();
    start1 = 1'b0;
    flags1("A.e0", 8'h00, 1'b1, 1'b0, 1'b0);
    for (int k = 1; k <= 5; k++) begin
      tick();
      flags1("A.step", 8'(k), (k != 5), (k == 5), 1'b0);
    end
    tick();
    flags1("A.after", 8'h05, 1'b0, 1'b0, 1'b0);

    // Walk up to 98 for the wrap test.
    start1 = 1'b1; tgt1 = 8'h98;
    tick();
    start1 = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (done1) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    check("B.reach98", 16'(ok), 16'h1);
    flags1("B.at98", 8'h98, 1'b0, 1'b1, 1'b0);
    tick();

    // 98 -> 01 up through the full wrap.
    start1 = 1'b1; x1 = 1'b0; tgt1 = 8'h01;
    tick();
    start1 = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      flags1("B.wrap", seq_b[k], (k != 2), (k == 2), 1'b0);
    end
    tick();

    // 01 -> 97 down through the full wrap; x/target changes mid-run ignored.
    start1 = 1'b1; x1 = 1'b1; tgt1 = 8'h97;
    tick();
    start1 = 1'b0; x1 = 1'b0; tgt1 = 8'h55;
    for (int k = 0; k < 4; k++) begin
      tick();
      flags1("C.wrap", seq_c[k], (k != 3), (k == 3), 1'b0);
    end
    tick();

    // Invalid target pulses err, then same-value start pulses done.
    start1 = 1'b1; x1 = 1'b0; tgt1 = 8'h1A;
    tick();
    start1 = 1'b0;
    flags1("D.err", 8'h97, 1'b0, 1'b0, 1'b1);
    tick();
    flags1("D.err_off", 8'h97, 1'b0, 1'b0, 1'b0);
    start1 = 1'b1; tgt1 = 8'h97;
    tick();
    start1 = 1'b0;
    flags1("D.same", 8'h97, 1'b0, 1'b1, 1'b0);
    tick();
    flags1("D.same_off", 8'h97, 1'b0, 1'b0, 1'b0);

    // abort in IDLE is inert; start wins over abort; abort mid-run holds count.
    abort1 = 1'b1;
    tick();
    flags1("E.idle_abort", 8'h97, 1'b0, 1'b0, 1'b0);
    start1 = 1'b1; tgt1 = 8'h99;
    tick();
    start1 = 1'b0; abort1 = 1'b0;
    flags1("E.start_wins", 8'h97, 1'b1, 1'b0, 1'b0);
    tick();
    flags1("E.step", 8'h98, 1'b1, 1'b0, 1'b0);
    abort1 = 1'b1;
    tick();
    abort1 = 1'b0;
    flags1("E.abort", 8'h98, 1'b0, 1'b0, 1'b0);
    tick();
    flags1("E.hold", 8'h98, 1'b0, 1'b0, 1'b0);

    // STEP_DIV=3: 00 -> 04, aborted at 02.
    start3 = 1'b1; x3 = 1'b0; tgt3 = 8'h04;
    tick();
    start3 = 1'b0;
    flags3("F.e0", 8'h00, 1'b1, 1'b0, 1'b0);
    for (int k = 1; k <= 6; k++) begin
      tick();
      flags3("F.div", 8'(k / 3), 1'b1, 1'b0, 1'b0);
    end
    abort3 = 1'b1;
    tick();
    abort3 = 1'b0;
    flags3("F.abort", 8'h02, 1'b0, 1'b0, 1'b0);
    tick();
    flags3("F.hold", 8'h02, 1'b0, 1'b0, 1'b0);

    // rst on the edge that would finish the run discards the done.
    start3 = 1'b1; tgt3 = 8'h04;
    tick();
    start3 = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      tick();
      flags3("G.run", 8'(2 + k / 3), 1'b1, 1'b0, 1'b0);
    end
    rst3 = 1'b1;
    tick();
    rst3 = 1'b0;
    flags3("G.rst", 8'h00, 1'b0, 1'b0, 1'b0);
    tick();
    flags3("G.after", 8'h00, 1'b0, 1'b0, 1'b0);

`ifdef BCD_SEQ_LOAD_EN
    // Load 42, count down to 40; load beats start; invalid load pulses err.
    load1 = 1'b1; lval1 = 8'h42; start1 = 1'b1; x1 = 1'b1; tgt1 = 8'h40;
    tick();
    load1 = 1'b0; start1 = 1'b0;
    flags1("H.load", 8'h42, 1'b0, 1'b0, 1'b0);
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    flags1("H.e0", 8'h42, 1'b1, 1'b0, 1'b0);
    tick();
    flags1("H.s1", 8'h41, 1'b1, 1'b0, 1'b0);
    tick();
    flags1("H.s2", 8'h40, 1'b0, 1'b1, 1'b0);
    load1 = 1'b1; lval1 = 8'hB0;
    tick();
    load1 = 1'b0;
    flags1("H.badload", 8'h40, 1'b0, 1'b0, 1'b1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
